// File: rtl/mem_data_axi_bridge_if.sv
// AXI4 channel bundle between the data-side bridge (master) and its memory slave.
// All five channels carry single-beat transfers only; widths are fixed at 32-bit data/address.
interface mem_data_axi_bridge_if;
  // read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  // write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/mem_data_axi_bridge.sv
// Data-side bridge: turns each EX data_sram request into one single-beat AXI4 read or write,
// stalling the pipeline until it completes and pulsing rdata_valid when load data returns.
module mem_data_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'b0001,
  parameter int         DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [DATA_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              rdata_valid,
  output logic              stallreq_for_mem,
  output logic [2:0]        dbg_state,
  mem_data_axi_bridge_if.master axi
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge where
  // valid and ready are both 1; once valid rises it holds, payload stable, until that edge.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wen_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_valid_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              aw_done;
  logic              w_done;

  logic aw_hs;
  logic w_hs;
  logic aw_ok;
  logic w_ok;

  assign aw_hs = awvalid_q & axi.awready;
  assign w_hs  = wvalid_q & axi.wready;
  assign aw_ok = aw_done | aw_hs;
  assign w_ok  = w_done | w_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wen_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_sram_en) begin
            addr_q  <= data_sram_addr;
            wen_q   <= data_sram_wen;
            wdata_q <= data_sram_wdata;
            if (data_sram_wen == 4'b0000) begin
              state     <= RD_AR;
              arvalid_q <= 1'b1;
            end else begin
              state     <= WR_AW_W;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end
          end
        end
        RD_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_R;
          end
        end
        RD_R: begin
          if (axi.rvalid) begin
            rready_q      <= 1'b0;
            rdata_q       <= axi.rdata;
            rdata_valid_q <= 1'b1;
            state         <= DONE;
          end
        end
        WR_AW_W: begin
          // Address and data channels retire independently; move on once both have.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state    <= WR_B;
          end
        end
        WR_B: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          // EX still shows the finished request here, so data_sram_en is deliberately ignored.
          rdata_valid_q <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The requesting IDLE cycle must already stall, hence the combinational term.
  always_comb begin
    stallreq_for_mem = 1'b0;
    case (state)
      IDLE:                           stallreq_for_mem = data_sram_en;
      RD_AR, RD_R, WR_AW_W, WR_B:     stallreq_for_mem = 1'b1;
      default:                        stallreq_for_mem = 1'b0;
    endcase
  end

  assign data_sram_rdata = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign dbg_state       = state;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = {addr_q[31:2], 2'b00};
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = {addr_q[31:2], 2'b00};
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wen_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  // Response IDs, status and rlast carry nothing this bridge acts on.
  logic unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule
